// File: rtl/feed_msg_arbiter.sv
// Packet-atomic round-robin merge of C_NUM_PORTS Avalon-ST message streams behind one registered output stage.
// Optional build macro FEED_ARB_CHANNEL_EN adds the out_channel port (source port of each forwarded beat).
module feed_msg_arbiter #(
  parameter int C_NUM_PORTS       = 4,
  parameter int C_PKT_DATA_WIDTH  = 64,
  parameter int C_PKT_EMPTY_WIDTH = $clog2(C_PKT_DATA_WIDTH/8),
  parameter int C_IDX_WIDTH       = $clog2(C_NUM_PORTS)
) (
  input  logic                                     clk,
  input  logic                                     reset,
  output logic [C_NUM_PORTS-1:0]                   in_ready,
  input  logic [C_NUM_PORTS-1:0]                   in_valid,
  input  logic [C_NUM_PORTS-1:0]                   in_startofpacket,
  input  logic [C_NUM_PORTS-1:0]                   in_endofpacket,
  input  logic [C_NUM_PORTS*C_PKT_DATA_WIDTH-1:0]  in_data,
  input  logic [C_NUM_PORTS*C_PKT_EMPTY_WIDTH-1:0] in_empty,
  input  logic [C_NUM_PORTS-1:0]                   in_error,
  input  logic                                     out_ready,
  output logic                                     out_valid,
  output logic                                     out_startofpacket,
  output logic                                     out_endofpacket,
  output logic                                     out_error,
  output logic [C_PKT_DATA_WIDTH-1:0]              out_data,
  output logic [C_PKT_EMPTY_WIDTH-1:0]             out_empty,
`ifdef FEED_ARB_CHANNEL_EN
  output logic [C_IDX_WIDTH-1:0]                   out_channel,
`endif
  output logic                                     stat_drop
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state;
  logic [C_IDX_WIDTH-1:0]  grant;
  logic [C_IDX_WIDTH-1:0]  rr_ptr;

  logic [C_NUM_PORTS-1:0]  cand;
  logic [C_NUM_PORTS-1:0]  gmask;
  logic [C_NUM_PORTS-1:0]  orphan;
  logic [C_IDX_WIDTH-1:0]  winner;
  logic                    found;
  logic                    stage_free;
  logic                    accept;

  logic [C_PKT_DATA_WIDTH-1:0]  g_data;
  logic [C_PKT_EMPTY_WIDTH-1:0] g_empty;
  logic                         g_sop;
  logic                         g_eop;
  logic                         g_err;

  // Port index base+off, wrapped modulo C_NUM_PORTS (off < C_NUM_PORTS).
  function automatic logic [C_IDX_WIDTH-1:0] rr_idx(input logic [C_IDX_WIDTH-1:0] base,
                                                   input int off);
    int s;
    s = int'(base) + off;
    if (s >= C_NUM_PORTS) s = s - C_NUM_PORTS;
    return C_IDX_WIDTH'(s);
  endfunction

  always_comb begin
    gmask = '0;
    if (state == BUSY) gmask[grant] = 1'b1;
    cand   = in_valid & in_startofpacket;
    // Mid-message beats with no owner are swallowed so a broken source cannot stall its port.
    orphan = in_valid & ~in_startofpacket & ~gmask;
    stage_free = !out_valid || out_ready;
    in_ready = orphan;
    if (state == BUSY) in_ready[grant] = stage_free;
    accept = (state == BUSY) && in_valid[grant] && stage_free;
  end

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < C_NUM_PORTS; i++) begin
      if (!found && cand[rr_idx(rr_ptr, i)]) begin
        winner = rr_idx(rr_ptr, i);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    g_data  = in_data[int'(grant)*C_PKT_DATA_WIDTH +: C_PKT_DATA_WIDTH];
    g_empty = in_empty[int'(grant)*C_PKT_EMPTY_WIDTH +: C_PKT_EMPTY_WIDTH];
    g_sop   = in_startofpacket[grant];
    g_eop   = in_endofpacket[grant];
    g_err   = in_error[grant];
  end

  // Arbitration FSM and the single registered output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      grant             <= '0;
      rr_ptr            <= '0;
      out_valid         <= 1'b0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_error         <= 1'b0;
      out_data          <= '0;
      out_empty         <= '0;
`ifdef FEED_ARB_CHANNEL_EN
      out_channel       <= '0;
`endif
      stat_drop         <= 1'b0;
    end else begin
      stat_drop <= |orphan;
      case (state)
        IDLE: begin
          if (found) begin
            grant <= winner;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (accept && g_eop) begin
            state  <= IDLE;
            rr_ptr <= rr_idx(grant, 1);
          end
        end
      endcase
      if (accept) begin
        out_valid         <= 1'b1;
        out_startofpacket <= g_sop;
        out_endofpacket   <= g_eop;
        out_error         <= g_err;
        out_data          <= g_data;
        out_empty         <= g_empty;
`ifdef FEED_ARB_CHANNEL_EN
        out_channel       <= grant;
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_feed_msg_arbiter.sv
// Randomized and directed bench for feed_msg_arbiter against a message-level round-robin model.
// Build with FEED_ARB_CHANNEL_EN defined to also cover out_channel.
module tb_feed_msg_arbiter;

  localparam int NP = 4;
  localparam int W  = 64;
  localparam int E  = $clog2(W/8);
  localparam int IW = $clog2(NP);

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [NP-1:0]   in_ready;
  logic [NP-1:0]   in_valid = '0;
  logic [NP-1:0]   in_startofpacket = '0;
  logic [NP-1:0]   in_endofpacket = '0;
  logic [NP*W-1:0] in_data = '0;
  logic [NP*E-1:0] in_empty = '0;
  logic [NP-1:0]   in_error = '0;
  logic            out_ready = 1'b1;
  logic            out_valid;
  logic            out_startofpacket;
  logic            out_endofpacket;
  logic            out_error;
  logic [W-1:0]    out_data;
  logic [E-1:0]    out_empty;
`ifdef FEED_ARB_CHANNEL_EN
  logic [IW-1:0]   out_channel;
`endif
  logic            stat_drop;

  always #5 clk = ~clk;

  feed_msg_arbiter #(
    .C_NUM_PORTS(NP),
    .C_PKT_DATA_WIDTH(W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_ready(in_ready),
    .in_valid(in_valid),
    .in_startofpacket(in_startofpacket),
    .in_endofpacket(in_endofpacket),
    .in_data(in_data),
    .in_empty(in_empty),
    .in_error(in_error),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_startofpacket(out_startofpacket),
    .out_endofpacket(out_endofpacket),
    .out_error(out_error),
    .out_data(out_data),
    .out_empty(out_empty),
`ifdef FEED_ARB_CHANNEL_EN
    .out_channel(out_channel),
`endif
    .stat_drop(stat_drop)
  );

  typedef struct packed {
    logic [W-1:0]  data;
    logic [E-1:0]  empty;
    logic          sop;
    logic          eop;
    logic          err;
    logic [IW-1:0] port;
  } beat_t;

  beat_t src_q [NP][$];
  beat_t pend  [NP][$];
  beat_t obs_q [$];
  beat_t exp_q [$];
  int    obs_cyc [$];

  int n_checks;
  int n_fail;
  int cyc;
  logic ordy_req;

  logic [NP-1:0] smp_ready;
  logic          smp_oval, smp_ordy, smp_osop, smp_oeop, smp_oerr, smp_drop;
  logic [W-1:0]  smp_odata;
  logic [E-1:0]  smp_oempty;

`ifdef FEED_ARB_CHANNEL_EN
  function automatic logic [W+E+3+IW-1:0] fields(beat_t b);
    return {b.data, b.empty, b.sop, b.eop, b.err, b.port};
  endfunction
`else
  function automatic logic [W+E+3-1:0] fields(beat_t b);
    return {b.data, b.empty, b.sop, b.eop, b.err};
  endfunction
`endif

  // One clock: drive sources at negedge, sample just after, retire accepted beats at posedge.
  task automatic cycle();
    logic [NP-1:0] acc;
    beat_t ob;
    @(negedge clk);
    out_ready = ordy_req;
    for (int p = 0; p < NP; p++) begin
      if (src_q[p].size() > 0) begin
        in_valid[p]         = 1'b1;
        in_startofpacket[p] = src_q[p][0].sop;
        in_endofpacket[p]   = src_q[p][0].eop;
        in_error[p]         = src_q[p][0].err;
        in_data[p*W +: W]   = src_q[p][0].data;
        in_empty[p*E +: E]  = src_q[p][0].empty;
      end else begin
        in_valid[p]         = 1'b0;
        in_startofpacket[p] = 1'b0;
        in_endofpacket[p]   = 1'b0;
        in_error[p]         = 1'b0;
      end
    end
    #1;
    smp_ready  = in_ready;
    smp_oval   = out_valid;
    smp_ordy   = out_ready;
    smp_osop   = out_startofpacket;
    smp_oeop   = out_endofpacket;
    smp_oerr   = out_error;
    smp_odata  = out_data;
    smp_oempty = out_empty;
    smp_drop   = stat_drop;
    if (out_valid && out_ready) begin
      ob.data  = out_data;
      ob.empty = out_empty;
      ob.sop   = out_startofpacket;
      ob.eop   = out_endofpacket;
      ob.err   = out_error;
`ifdef FEED_ARB_CHANNEL_EN
      ob.port  = out_channel;
`else
      ob.port  = '0;
`endif
      obs_q.push_back(ob);
      obs_cyc.push_back(cyc);
    end
    acc = in_valid & in_ready;
    @(posedge clk);
    for (int p = 0; p < NP; p++)
      if (acc[p]) void'(src_q[p].pop_front());
    cyc++;
  endtask

  task automatic clear_all();
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      pend[p].delete();
    end
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    clear_all();
    ordy_req = 1'b1;
    reset = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
    clear_all();
  endtask

  task automatic push_beat(int p, beat_t b);
    src_q[p].push_back(b);
    pend[p].push_back(b);
  endtask

  task automatic push_msg(int p, int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data  = {$urandom, $urandom};
      b.empty = E'($urandom);
      b.err   = 1'($urandom);
      b.sop   = (k == 0);
      b.eop   = (k == len - 1);
      b.port  = IW'(p);
      push_beat(p, b);
    end
  endtask

  // Reference: whole messages leave in round-robin order over ports with pending messages.
  task automatic rr_model(int start);
    int ptr;
    int p;
    bit any;
    beat_t b;
    ptr = start;
    forever begin
      any = 0;
      for (int i = 0; i < NP && !any; i++) begin
        p = (ptr + i) % NP;
        if (pend[p].size() > 0) any = 1;
      end
      if (!any) break;
      do begin
        b = pend[p].pop_front();
        exp_q.push_back(b);
      end while (!b.eop);
      ptr = (p + 1) % NP;
    end
  endtask

  task automatic run_until_done(int budget);
    for (int k = 0; k < budget && obs_q.size() < exp_q.size(); k++) cycle();
    repeat (3) cycle();
  endtask

  task automatic test_reset();
    clear_all();
    reset = 1'b1;
    ordy_req = 1'b1;
    repeat (3) cycle();
    reset = 1'b0;
    cycle();
    n_checks++;
    if (smp_oval !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", smp_oval); end
    n_checks++;
    if ({smp_osop, smp_oeop, smp_oerr} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000", {smp_osop, smp_oeop, smp_oerr});
    end
    n_checks++;
    if (smp_odata !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", smp_odata); end
    n_checks++;
    if (smp_oempty !== '0) begin n_fail++; $display("FAIL reset_out_empty: got %0d want 0", smp_oempty); end
    n_checks++;
    if (smp_drop !== 1'b0) begin n_fail++; $display("FAIL reset_stat_drop: got %b want 0", smp_drop); end
    n_checks++;
    if (smp_ready !== '0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", smp_ready); end
`ifdef FEED_ARB_CHANNEL_EN
    n_checks++;
    if (out_channel !== '0) begin n_fail++; $display("FAIL reset_out_channel: got %0d want 0", out_channel); end
`endif
  endtask

  task automatic test_three_beat();
    beat_t b;
    logic [W-1:0] dpat [3];
    int t;
    do_reset();
    dpat[0] = 64'h1111_1111_1111_1111;
    dpat[1] = 64'h2222_2222_2222_2222;
    dpat[2] = 64'h3333_3333_3333_3333;
    for (int k = 0; k < 3; k++) begin
      b.data = dpat[k]; b.sop = (k == 0); b.eop = (k == 2);
      b.empty = (k == 2) ? E'(5) : E'(0); b.err = 1'b0; b.port = IW'(2);
      push_beat(2, b);
    end
    t = cyc;
    repeat (10) cycle();
    n_checks++;
    if (obs_q.size() !== 3) begin n_fail++; $display("FAIL three_count: got %0d beats want 3", obs_q.size()); end
    for (int k = 0; k < 3 && k < obs_q.size(); k++) begin
      n_checks++;
      if (obs_cyc[k] !== t + 2 + k) begin
        n_fail++; $display("FAIL three_timing%0d: got cycle %0d want %0d", k, obs_cyc[k], t + 2 + k);
      end
      n_checks++;
      if (obs_q[k].data !== dpat[k] || obs_q[k].sop !== (k == 0) || obs_q[k].eop !== (k == 2)) begin
        n_fail++; $display("FAIL three_beat%0d: got %h sop %b eop %b want %h", k, obs_q[k].data,
                           obs_q[k].sop, obs_q[k].eop, dpat[k]);
      end
    end
    if (obs_q.size() == 3) begin
      n_checks++;
      if (obs_q[2].empty !== E'(5)) begin n_fail++; $display("FAIL three_empty: got %0d want 5", obs_q[2].empty); end
    end
    // Pointer now sits after port 2: a simultaneous start on every port must begin at port 3.
    clear_all();
    for (int p = 0; p < NP; p++) push_msg(p, 1);
    rr_model(3);
    run_until_done(40);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL rrptr_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (fields(obs_q[i]) !== fields(exp_q[i])) begin
        n_fail++; $display("FAIL rrptr_beat%0d: got %h want %h", i, fields(obs_q[i]), fields(exp_q[i]));
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) push_msg(p, 2);
    rr_model(0);
    run_until_done(100);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL rr_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (fields(obs_q[i]) !== fields(exp_q[i])) begin
        n_fail++; $display("FAIL rr_beat%0d: got %h want %h", i, fields(obs_q[i]), fields(exp_q[i]));
      end
    end
    for (int i = 0; i + 1 < obs_q.size(); i++) begin
      n_checks++;
      if (obs_cyc[i+1] - obs_cyc[i] !== (obs_q[i].eop ? 2 : 1)) begin
        n_fail++; $display("FAIL rr_gap%0d: got gap %0d want %0d", i, obs_cyc[i+1] - obs_cyc[i],
                           obs_q[i].eop ? 2 : 1);
      end
    end
  endtask

  task automatic test_backpressure();
    bit pat [4];
    int seen;
    logic [W-1:0] held;
    bit holding;
    do_reset();
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
    push_msg(1, 4);
    rr_model(0);
    seen = 0;
    holding = 0;
    for (int k = 0; k < 30; k++) begin
      ordy_req = (seen < 4) ? pat[seen] : 1'b1;
      cycle();
      if (holding) begin
        n_checks++;
        if (!smp_oval || smp_odata !== held) begin
          n_fail++; $display("FAIL bp_hold: got valid %b data %h want 1 %h", smp_oval, smp_odata, held);
        end
      end
      holding = 0;
      if (smp_oval && !smp_ordy) begin
        n_checks++;
        if (smp_ready[1] !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", smp_ready[1]); end
        held = smp_odata;
        holding = 1;
      end
      if (smp_oval) seen++;
    end
    ordy_req = 1'b1;
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL bp_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (fields(obs_q[i]) !== fields(exp_q[i])) begin
        n_fail++; $display("FAIL bp_beat%0d: got %h want %h", i, fields(obs_q[i]), fields(exp_q[i]));
      end
    end
  endtask

  task automatic test_orphan();
    beat_t b;
    int drops;
    do_reset();
    push_msg(0, 4);
    rr_model(0);
    drops = 0;
    repeat (2) begin cycle(); drops += int'(smp_drop); end
    b.data = {$urandom, $urandom}; b.empty = '0; b.err = 1'b0;
    b.sop = 1'b0; b.eop = 1'b1; b.port = IW'(1);
    src_q[1].push_back(b);
    repeat (15) begin cycle(); drops += int'(smp_drop); end
    n_checks++;
    if (drops !== 1) begin n_fail++; $display("FAIL orphan_drop_pulses: got %0d want 1", drops); end
    n_checks++;
    if (src_q[1].size() !== 0) begin n_fail++; $display("FAIL orphan_consumed: got %0d left want 0", src_q[1].size()); end
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL orphan_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (fields(obs_q[i]) !== fields(exp_q[i])) begin
        n_fail++; $display("FAIL orphan_beat%0d: got %h want %h", i, fields(obs_q[i]), fields(exp_q[i]));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_msg(2, 4);
    for (int k = 0; k < 20 && obs_q.size() < 2; k++) cycle();
    n_checks++;
    if (obs_q.size() !== 2) begin n_fail++; $display("FAIL rmid_prefix: got %0d beats want 2", obs_q.size()); end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    clear_all();
    cycle();
    n_checks++;
    if (smp_oval !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid: got %b want 0", smp_oval); end
    push_msg(3, 2);
    push_msg(1, 1);
    rr_model(0);
    run_until_done(40);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL rmid_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (fields(obs_q[i]) !== fields(exp_q[i])) begin
        n_fail++; $display("FAIL rmid_beat%0d: got %h want %h", i, fields(obs_q[i]), fields(exp_q[i]));
      end
    end
  endtask

  task automatic test_single_beat();
    beat_t b;
    do_reset();
    b.data = {$urandom, $urandom}; b.empty = E'($urandom); b.err = 1'b1;
    b.sop = 1'b1; b.eop = 1'b1; b.port = IW'(3);
    push_beat(3, b);
    repeat (8) cycle();
    n_checks++;
    if (obs_q.size() !== 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      n_checks++;
      if ({obs_q[0].sop, obs_q[0].eop, obs_q[0].err} !== 3'b111 || obs_q[0].data !== b.data ||
          obs_q[0].empty !== b.empty) begin
        n_fail++; $display("FAIL single_beat: got %h want %h", fields(obs_q[0]), fields(b));
      end
`ifdef FEED_ARB_CHANNEL_EN
      n_checks++;
      if (obs_q[0].port !== IW'(3)) begin n_fail++; $display("FAIL single_channel: got %0d want 3", obs_q[0].port); end
`endif
    end
  endtask

  task automatic test_random();
    int drops;
    do_reset();
    for (int p = 0; p < NP; p++) begin
      int nm;
      nm = $urandom_range(1, 4);
      for (int m = 0; m < nm; m++) push_msg(p, $urandom_range(1, 4));
    end
    rr_model(0);
    drops = 0;
    for (int k = 0; k < 3000 && obs_q.size() < exp_q.size(); k++) begin
      ordy_req = ($urandom_range(0, 3) != 0);
      cycle();
      drops += int'(smp_drop);
    end
    ordy_req = 1'b1;
    n_checks++;
    if (drops !== 0) begin n_fail++; $display("FAIL rand_drops: got %0d want 0", drops); end
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (fields(obs_q[i]) !== fields(exp_q[i])) begin
        n_fail++; $display("FAIL rand_beat%0d: got %h want %h", i, fields(obs_q[i]), fields(exp_q[i]));
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    ordy_req = 1'b1;
    test_reset();
    test_three_beat();
    test_round_robin();
    test_backpressure();
    test_orphan();
    test_reset_mid();
    test_single_beat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
